param_quantizer: RTL and testbench

PARAM_QUANTIZER -- requirements
Module: param_quantizer

---
 rtl/param_quantizer.sv | 150 +++++++++++++++
 tb/tb_param_quantizer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_quantizer.sv
// JPEG coefficient quantizer: multiply by a ROM reciprocal of the 8x8 Q table, round, saturate; 3-cycle latency.
// Whole pipeline stalls only while the output holds an unaccepted coefficient; in_ready follows that combinationally.
module param_quantizer #(
    parameter int IN_W   = 11,
    parameter int OUT_W  = 11,
    parameter int FRAC_W = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [5:0]              out_index,
    output logic                    out_last,
    output logic [15:0]             blk_count
);

    localparam int RW   = FRAC_W + 2;
    localparam int PW   = IN_W + FRAC_W + 2;
    localparam int RSW  = IN_W + 3;
    localparam int OMAX = (1 << (OUT_W - 1)) - 1;
    localparam int OMIN = -(1 << (OUT_W - 1));

    // Entries 0..63 luma, 64..127 chroma, raster order.
    localparam int Q_TAB [128] = '{
        16, 11, 10, 16, 24, 40, 51, 61,
        12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,
        14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77,
        24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103, 99,
        17, 18, 24, 47, 99, 99, 99, 99,
        18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,
        47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99
    };

    logic [RW-1:0] recip_rom [128];
    for (genvar g = 0; g < 128; g++) begin : g_rom
        assign recip_rom[g] = RW'((1 << FRAC_W) / Q_TAB[g]);
    end

    logic                    rdy_en_q;
    logic [5:0]              idx_q;
    logic                    mode_q;
    logic                    s1_vld_q, s2_vld_q, s3_vld_q, out_vld_q;
    logic signed [IN_W-1:0]  s1_dat_q, s2_dat_q;
    logic [5:0]              s1_idx_q, s2_idx_q, s3_idx_q, out_idx_q;
    logic                    s1_tbl_q;
    logic [RW-1:0]           s2_rcp_q;
    logic signed [PW-1:0]    s3_prod_q;
    logic signed [OUT_W-1:0] out_dat_q;
    logic                    out_last_q;
    logic [15:0]             blk_cnt_q;

    logic                    advance, in_fire, tbl_d;
    logic [RW-1:0]           rcp_d;
    logic signed [PW-1:0]    prod_d;
    logic signed [RSW-1:0]   rnd_d;
    logic signed [OUT_W-1:0] out_dat_d;

    assign advance  = !out_vld_q || out_ready;
    assign in_ready = rdy_en_q && advance;
    assign in_fire  = in_valid && in_ready;
    // The first coefficient of a block uses the live mode; the rest use the latched copy.
    assign tbl_d    = (idx_q == 6'd0) ? mode : mode_q;
    assign rcp_d    = recip_rom[{s1_tbl_q, s1_idx_q}];
    assign prod_d   = PW'(s2_dat_q) * PW'($signed(s2_rcp_q));
    assign rnd_d    = RSW'(s3_prod_q >>> FRAC_W) + RSW'(s3_prod_q[FRAC_W-1]);

    always_comb begin
        out_dat_d = OUT_W'(rnd_d);
        if (int'(rnd_d) > OMAX) begin
            out_dat_d = OUT_W'(OMAX);
        end else if (int'(rnd_d) < OMIN) begin
            out_dat_d = OUT_W'(OMIN);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdy_en_q   <= 1'b0;
            idx_q      <= '0;
            mode_q     <= 1'b0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s3_vld_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            s1_dat_q   <= '0;
            s2_dat_q   <= '0;
            s1_idx_q   <= '0;
            s2_idx_q   <= '0;
            s3_idx_q   <= '0;
            out_idx_q  <= '0;
            s1_tbl_q   <= 1'b0;
            s2_rcp_q   <= '0;
            s3_prod_q  <= '0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
            blk_cnt_q  <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (in_fire) begin
                idx_q <= idx_q + 6'd1;
                if (idx_q == 6'd0) begin
                    mode_q <= mode;
                end
            end
            if (advance) begin
                s1_vld_q   <= in_fire;
                s1_dat_q   <= in_data;
                s1_idx_q   <= idx_q;
                s1_tbl_q   <= tbl_d;
                s2_vld_q   <= s1_vld_q;
                s2_dat_q   <= s1_dat_q;
                s2_rcp_q   <= rcp_d;
                s2_idx_q   <= s1_idx_q;
                s3_vld_q   <= s2_vld_q;
                s3_prod_q  <= prod_d;
                s3_idx_q   <= s2_idx_q;
                out_vld_q  <= s3_vld_q;
                out_last_q <= s3_vld_q && (s3_idx_q == 6'd63);
                if (s3_vld_q) begin
                    out_dat_q <= out_dat_d;
                    out_idx_q <= s3_idx_q;
                end
            end
            if (out_vld_q && out_ready && out_last_q) begin
                blk_cnt_q <= blk_cnt_q + 16'd1;
            end
        end
    end

    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign out_index = out_idx_q;
    assign out_last  = out_last_q;
    assign blk_count = blk_cnt_q;

endmodule

// File: tb/tb_param_quantizer.sv
// Scoreboard bench for param_quantizer: driver pushes model results, monitor pops on each output transfer.
module tb_param_quantizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               in_valid, in_ready, mode;
    logic signed [10:0] in_data;
    logic               out_valid, out_ready, out_last;
    logic signed [10:0] out_data;
    logic [5:0]         out_index;
    logic [15:0]        blk_count;

    logic               s_in_valid, s_in_ready, s_mode, s_out_valid, s_out_ready, s_out_last;
    logic signed [10:0] s_in_data;
    logic signed [5:0]  s_out_data;
    logic [5:0]         s_out_index;
    logic [15:0]        s_blk_count;

    param_quantizer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .blk_count(blk_count)
    );

    param_quantizer #(.OUT_W(6)) u_sat (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .mode(s_mode), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .out_index(s_out_index), .out_last(s_out_last), .blk_count(s_blk_count)
    );

    localparam int QL [64] = '{
        16, 11, 10, 16, 24, 40, 51, 61,   12, 12, 14, 19, 26, 58, 60, 55,
        14, 13, 16, 24, 40, 57, 69, 56,   14, 17, 22, 29, 51, 87, 80, 62,
        18, 22, 37, 56, 68, 109, 103, 77, 24, 35, 55, 64, 81, 104, 113, 92,
        49, 64, 78, 87, 103, 121, 120, 101, 72, 92, 95, 98, 112, 100, 103, 99};
    localparam int QC [64] = '{
        17, 18, 24, 47, 99, 99, 99, 99,   18, 21, 26, 66, 99, 99, 99, 99,
        24, 26, 56, 99, 99, 99, 99, 99,   47, 66, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99,
        99, 99, 99, 99, 99, 99, 99, 99,   99, 99, 99, 99, 99, 99, 99, 99};

    typedef struct {
        int data;
        int idx;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_idx = 0;
    bit   m_mode = 1'b0;
    int   m_blk = 0;
    bit   rand_rdy = 1'b0;
    int   cap [64];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: floor(x*r/2^12) plus one when the dropped fraction is at least one half.
    function automatic int model_q(input int x, input bit tbl, input int idx, input int ow);
        int     q, hi, lo;
        longint r, p, fl, res;
        q  = tbl ? QC[idx] : QL[idx];
        r  = 4096 / q;
        p  = longint'(x) * r;
        fl = (p >= 0) ? p / 4096 : -((-p + 4095) / 4096);
        res = fl + (((p - fl * 4096) >= 2048) ? 1 : 0);
        hi = (1 << (ow - 1)) - 1;
        lo = -(1 << (ow - 1));
        if (res > hi) res = hi;
        if (res < lo) res = lo;
        return int'(res);
    endfunction

    task automatic push_model(input int d, input bit md);
        exp_t e;
        if (m_idx == 0) m_mode = md;
        e.data = model_q(d, m_mode, m_idx, 11);
        e.idx  = m_idx;
        e.last = (m_idx == 63);
        sb.push_back(e);
        m_idx = (m_idx + 1) % 64;
    endtask

    task automatic xfer(input int d, input bit md);
        bit done;
        done = 1'b0;
        for (int t = 0; t < 100 && !done; t++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            in_data   = 11'(d);
            mode      = md;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (in_ready) begin
                push_model(d, md);
                done = 1'b1;
            end
        end
        chk("xfer_accept", int'(done), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && sb.size() != 0; t++) idle(1);
        chk("drain_empty", sb.size(), 0);
        idle(2);
    endtask

    task automatic send_block(input int d, input bit md);
        for (int i = 0; i < 64; i++) xfer(d, md);
    endtask

    // Monitor: samples mid-cycle, after the driver has settled inputs for the coming edge.
    initial begin
        bit          prev_stall;
        logic [10:0] pd;
        logic [5:0]  pi;
        logic        pl;
        exp_t        e;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    chk("stall_hold", int'({out_valid, out_data, out_index, out_last}),
                        int'({1'b1, pd, pi, pl}));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", int'(out_index), -1);
                    end else begin
                        e = sb.pop_front();
                        chk("out_data", int'(out_data), e.data);
                        chk("out_index", int'(out_index), e.idx);
                        chk("out_last", int'(out_last), int'(e.last));
                        chk("blk_count", int'(blk_count), m_blk);
                        cap[e.idx] = int'(out_data);
                        if (e.last) m_blk = (m_blk + 1) % 65536;
                    end
                end
                prev_stall = out_valid && !out_ready;
                pd = out_data;
                pi = out_index;
                pl = out_last;
            end
        end
    end

    initial begin
        int sat_got [$];
        int sat_idx [$];
        bit md;
        rst = 1'b0; in_valid = 1'b0; in_data = '0; mode = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_mode = 1'b0; s_out_ready = 1'b1;

        repeat (2) @(negedge clk);
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_index", int'(out_index), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_blk_count", int'(blk_count), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rel_in_ready_low", int'(in_ready), 0);

        // Luma block of 1023s.
        send_block(1023, 1'b0);
        drain();
        chk("luma_idx0", cap[0], 64);
        chk("luma_idx63", cap[63], 10);
        chk("luma_blk", int'(blk_count), 1);

        // Chroma block of 1023s.
        send_block(1023, 1'b1);
        drain();
        chk("chroma_idx0", cap[0], 60);
        chk("chroma_blk", int'(blk_count), 2);

        // Latency of a lone coefficient into an empty pipeline, then the rest of the block.
        xfer(-1024, 1'b0);
        @(negedge clk); in_valid = 1'b0; #2;
        @(negedge clk); #2;
        @(negedge clk); #2;
        chk("lat_n2_invalid", int'(out_valid), 0);
        @(negedge clk); #2;
        chk("lat_n3_valid", int'(out_valid), 1);
        for (int i = 1; i < 64; i++) xfer(int'($urandom_range(0, 2047)) - 1024, 1'b0);
        drain();
        chk("neg_idx0", cap[0], -64);

        // mode flips at index 30: the block stays luma.
        for (int i = 0; i < 64; i++) xfer(1023, (i >= 30));
        drain();
        chk("toggle_idx31_luma", cap[31], 16);
        send_block(1023, 1'b1);
        drain();
        chk("next_idx31_chroma", cap[31], 10);

        // Random data, random mode wiggle, random gaps and random backpressure.
        rand_rdy = 1'b1;
        for (int b = 0; b < 3; b++) begin
            md = 1'($urandom_range(0, 1));
            for (int i = 0; i < 64; i++) begin
                xfer(int'($urandom_range(0, 2047)) - 1024, (i == 0) ? md : 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
        end
        drain();
        chk("rand_blk", int'(blk_count), 8);

        // Reset in the middle of a block.
        rand_rdy = 1'b0;
        for (int i = 0; i < 40; i++) xfer(1023, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_blk", int'(blk_count), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        sb.delete();
        m_idx = 0; m_mode = 1'b0; m_blk = 0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_rel_in_ready", int'(in_ready), 0);
        send_block(1023, 1'b1);
        drain();
        chk("postrst_idx0", cap[0], 60);
        chk("postrst_blk", int'(blk_count), 1);

        // Narrow-output instance saturates both ways.
        @(negedge clk); s_in_valid = 1'b1; s_in_data = 11'sd1023; #1;
        chk("sat_in_ready0", int'(s_in_ready), 1);
        @(negedge clk); s_in_data = -11'sd1024; #1;
        chk("sat_in_ready1", int'(s_in_ready), 1);
        @(negedge clk); s_in_valid = 1'b0;
        for (int t = 0; t < 20; t++) begin
            #2;
            if (s_out_valid) begin
                sat_got.push_back(int'(s_out_data));
                sat_idx.push_back(int'(s_out_index));
            end
            @(negedge clk);
        end
        chk("sat_count", sat_got.size(), 2);
        if (sat_got.size() == 2) begin
            chk("sat_pos", sat_got[0], 31);
            chk("sat_neg", sat_got[1], -32);
            chk("sat_idx1", sat_idx[1], 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
